// File: rtl/nand_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial NAND logic unit.
package nand_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/nand_bit_alu.sv
// One-bit AND/NAND/OR/XOR unit with a NAND-built 4:1 opcode mux.
module nand_bit_alu (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] op,
    output logic       r
);

    logic n_ab, and_r, a_n, b_n, or_r, x_p, x_q, xor_r;
    logic op0_n, op1_n, m0_a, m0_b, mux0, m1_a, m1_b, mux1, m2_a, m2_b;

    nand_cell u_nab  (.a(a),     .b(b),     .y(n_ab));
    nand_cell u_and  (.a(n_ab),  .b(n_ab),  .y(and_r));
    nand_cell u_inva (.a(a),     .b(a),     .y(a_n));
    nand_cell u_invb (.a(b),     .b(b),     .y(b_n));
    nand_cell u_or   (.a(a_n),   .b(b_n),   .y(or_r));
    nand_cell u_xp   (.a(a),     .b(n_ab),  .y(x_p));
    nand_cell u_xq   (.a(b),     .b(n_ab),  .y(x_q));
    nand_cell u_xor  (.a(x_p),   .b(x_q),   .y(xor_r));

    // op[0] picks within each pair (AND/NAND, OR/XOR), op[1] picks the pair.
    nand_cell u_ninv0 (.a(op[0]), .b(op[0]), .y(op0_n));
    nand_cell u_ninv1 (.a(op[1]), .b(op[1]), .y(op1_n));

    nand_cell u_m0a (.a(and_r), .b(op0_n), .y(m0_a));
    nand_cell u_m0b (.a(n_ab),  .b(op[0]), .y(m0_b));
    nand_cell u_m0  (.a(m0_a),  .b(m0_b),  .y(mux0));

    nand_cell u_m1a (.a(or_r),  .b(op0_n), .y(m1_a));
    nand_cell u_m1b (.a(xor_r), .b(op[0]), .y(m1_b));
    nand_cell u_m1  (.a(m1_a),  .b(m1_b),  .y(mux1));

    nand_cell u_m2a (.a(mux0),  .b(op1_n), .y(m2_a));
    nand_cell u_m2b (.a(mux1),  .b(op[1]), .y(m2_b));
    nand_cell u_m2  (.a(m2_a),  .b(m2_b),  .y(r));

endmodule

// File: rtl/nand_cell.sv
// Two-input NAND wrapper; the only logic cell used in the bit datapath.
module nand_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    nand g_nand (y, a, b);

endmodule

// File: rtl/nand_serial_logic_unit.sv
// Bit-serial AND/NAND/OR/XOR unit: LSB-first evaluation on a NAND-only bit datapath,
// with valid/ready handshakes on operands and result.
//
//   state   | meaning
//   IDLE    | waiting for operands, in_ready=1
//   RUN     | one result bit per clock, WIDTH clocks
//   DONE    | result and flags held until out_ready
module nand_serial_logic_unit
    import nand_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             red_and,
    output logic             red_or
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh, b_sh, y_upd;
    logic [1:0]         op_q;
    logic               bit_r, last_bit, accept;

    nand_bit_alu u_alu (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .op (op_q),
        .r  (bit_r)
    );

    // Result bits shift in from the MSB, so after WIDTH edges bit 0 holds the first result.
    generate
        if (WIDTH == 1) begin : g_y1
            assign y_upd = bit_r;
        end else begin : g_yn
            assign y_upd = {bit_r, y[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            op_q    <= '0;
            y       <= '0;
            red_and <= 1'b0;
            red_or  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_sh <= a;
                        b_sh <= b;
                        op_q <= op;
                        cnt  <= '0;
                        y    <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    y    <= y_upd;
                    if (last_bit) begin
                        red_and <= &y_upd;
                        red_or  <= |y_upd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_serial_logic_unit.sv
// Directed and randomized checks of the bit-serial NAND logic unit at WIDTH 8, 1 and 13.
module tb_nand_serial_logic_unit;
    import nand_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;
    logic [1:0]  op_in = '0;
    logic        iv8 = 0, iv1 = 0, iv13 = 0;
    logic        or8 = 0, or1 = 0, or13 = 0;

    logic        ir8, ov8, ra8, ro8;
    logic [7:0]  y8;
    logic        ir1, ov1, ra1, ro1;
    logic [0:0]  y1;
    logic        ir13, ov13, ra13, ro13;
    logic [12:0] y13;

    int          cur_w = 8;
    logic        ir_s, ov_s, ra_s, ro_s;
    logic [31:0] y_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nand_serial_logic_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a_in[7:0]), .b(b_in[7:0]), .op(op_in), .out_valid(ov8),
        .out_ready(or8), .y(y8), .red_and(ra8), .red_or(ro8));

    nand_serial_logic_unit #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a_in[0:0]), .b(b_in[0:0]), .op(op_in), .out_valid(ov1),
        .out_ready(or1), .y(y1), .red_and(ra1), .red_or(ro1));

    nand_serial_logic_unit #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13),
        .a(a_in[12:0]), .b(b_in[12:0]), .op(op_in), .out_valid(ov13),
        .out_ready(or13), .y(y13), .red_and(ra13), .red_or(ro13));

    always_comb begin
        ir_s = ir8; ov_s = ov8; ra_s = ra8; ro_s = ro8; y_s = {24'd0, y8};
        if (cur_w == 1) begin
            ir_s = ir1; ov_s = ov1; ra_s = ra1; ro_s = ro1; y_s = {31'd0, y1};
        end else if (cur_w == 13) begin
            ir_s = ir13; ov_s = ov13; ra_s = ra13; ro_s = ro13; y_s = {19'd0, y13};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        iv8 = (cur_w == 8) ? v : 1'b0;
        iv1 = (cur_w == 1) ? v : 1'b0;
        iv13 = (cur_w == 13) ? v : 1'b0;
    endtask

    task automatic set_oready(input logic v);
        or8 = (cur_w == 8) ? v : 1'b0;
        or1 = (cur_w == 1) ? v : 1'b0;
        or13 = (cur_w == 13) ? v : 1'b0;
    endtask

    function automatic logic [31:0] mask_of(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: whole-word logic operation, truncated to the unit width.
    function automatic logic [31:0] ref_y(input int w, input logic [31:0] ra,
                                          input logic [31:0] rb, input logic [1:0] rop);
        logic [31:0] res;
        case (rop)
            OP_AND:  res = ra & rb;
            OP_NAND: res = ~(ra & rb);
            OP_OR:   res = ra | rb;
            default: res = ra ^ rb;
        endcase
        return res & mask_of(w);
    endfunction

    // Entered and left at a negedge with the selected unit idle.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [1:0] top, input int hold);
        logic [31:0] exp_y;
        logic [31:0] held_y;
        int n;
        exp_y = ref_y(cur_w, ta, tb_v, top);
        check("idle_in_ready", {31'd0, ir_s}, 32'd1);
        a_in = ta; b_in = tb_v; op_in = top;
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0);
        n = 0;
        while (!ov_s && n < cur_w + 10) begin
            a_in = $urandom; b_in = $urandom; op_in = 2'($urandom);
            @(negedge clk);
            n++;
        end
        check("latency", n, cur_w);
        check("y", y_s, exp_y);
        check("red_and", {31'd0, ra_s}, {31'd0, exp_y == mask_of(cur_w)});
        check("red_or", {31'd0, ro_s}, {31'd0, exp_y != 32'd0});
        check("done_in_ready", {31'd0, ir_s}, 32'd0);
        held_y = y_s;
        for (int i = 0; i < hold; i++) begin
            a_in = $urandom; b_in = $urandom; set_valid(1'(i % 2 == 0));
            @(negedge clk);
            check("hold_y", y_s, held_y);
            check("hold_flags", {30'd0, ra_s, ro_s},
                  {30'd0, exp_y == mask_of(cur_w), exp_y != 32'd0});
            check("hold_valid_ready", {30'd0, ov_s, ir_s}, 32'd2);
        end
        set_valid(1'b0);
        set_oready(1'b1);
        @(negedge clk);
        set_oready(1'b0);
        check("back_to_idle", {30'd0, ov_s, ir_s}, 32'd1);
    endtask

    initial begin
        int seen;
        cur_w = 8;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {31'd0, ir_s}, 32'd1);
        check("reset_out_valid", {31'd0, ov_s}, 32'd0);
        check("reset_y", y_s, 32'd0);
        check("reset_flags", {30'd0, ra_s, ro_s}, 32'd0);

        run_op(32'hF0, 32'hCC, OP_AND, 0);
        run_op(32'hF0, 32'hCC, OP_NAND, 0);
        run_op(32'hF0, 32'hCC, OP_OR, 0);
        run_op(32'hF0, 32'hCC, OP_XOR, 0);
        run_op(32'hFF, 32'hFF, OP_AND, 0);
        run_op(32'h00, 32'h00, OP_OR, 0);
        run_op(32'hA5, 32'h3C, OP_XOR, 5);
        run_op(32'h12, 32'h34, OP_OR, 0);

        // Abort an operation in its fourth RUN cycle.
        a_in = 32'hF0; b_in = 32'hCC; op_in = OP_OR;
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_y", y_s, 32'd0);
        check("abort_valid_ready", {30'd0, ov_s, ir_s}, 32'd1);
        seen = 0;
        set_oready(1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov_s) seen++;
        end
        set_oready(1'b0);
        check("abort_no_result", seen, 0);
        run_op(32'h0F, 32'h55, OP_NAND, 2);

        cur_w = 1;
        @(negedge clk);
        run_op(32'h1, 32'h0, OP_XOR, 0);
        run_op(32'h1, 32'h1, OP_AND, 1);
        run_op(32'h1, 32'h1, OP_NAND, 0);

        cur_w = 13;
        @(negedge clk);
        for (int k = 0; k < 1000; k++)
            run_op($urandom, $urandom, 2'($urandom), int'($urandom_range(0, 2)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
